// File: rtl/osc_wave_shaper_if.sv
// Sample stream into and out of the wave shaper: phase samples in, shaped samples out.
`timescale 1ns/1ps
interface osc_wave_shaper_if #(
  parameter int V_WIDTH = 3,
  parameter int O_WIDTH = 2
);
  // Valid-only handshake: a beat transfers on every rising clock edge where its
  // valid is high. There is no ready, so the consumer must accept every beat.
  logic               in_valid;
  logic [10:0]        phase_acc;
  logic [V_WIDTH-1:0] vx;
  logic [O_WIDTH-1:0] ox;
  logic [1:0]         wave_sel;
  logic [10:0]        pulse_width;

  logic               out_valid;
  logic [15:0]        wave_out;
  logic [V_WIDTH-1:0] vx_out;
  logic [O_WIDTH-1:0] ox_out;
  logic               wrap_out;

  modport master (
    output in_valid, phase_acc, vx, ox, wave_sel, pulse_width,
    input  out_valid, wave_out, vx_out, ox_out, wrap_out
  );

  modport slave (
    input  in_valid, phase_acc, vx, ox, wave_sel, pulse_width,
    output out_valid, wave_out, vx_out, ox_out, wrap_out
  );
endinterface

// File: rtl/osc_wave_shaper.sv
// Converts time-multiplexed NCO phase samples into signed saw/pulse/triangle/sine
// samples and flags per-slot phase wrap. A fixed pipeline, one sample per clock.
`timescale 1ns/1ps
module osc_wave_shaper #(
  parameter int VOICES  = 8,
  parameter int V_OSC   = 4,
  parameter int V_WIDTH = 3,
  parameter int O_WIDTH = 2
) (
  input logic               sCLK_XVXOSC,
  input logic               reset_reg_N,
  osc_wave_shaper_if.slave  bus
);

  localparam int SLOTS = VOICES * V_OSC;

  // Input capture rank
  logic               r0_valid;
  logic [10:0]        r0_p;
  logic [V_WIDTH-1:0] r0_vx;
  logic [O_WIDTH-1:0] r0_ox;
  logic [1:0]         r0_sel;
  logic [10:0]        r0_pw;

  // Stage 1: wrap detection against per-slot previous phase MSB
  logic [SLOTS-1:0]   prev_msb;
  logic               s1_valid;
  logic [10:0]        s1_p;
  logic [V_WIDTH-1:0] s1_vx;
  logic [O_WIDTH-1:0] s1_ox;
  logic [1:0]         s1_sel;
  logic [10:0]        s1_pw;
  logic               s1_wrap;

  // Stage 2: shaped value, or the raw sine product m for wave_sel 3
  logic               s2_valid;
  logic [V_WIDTH-1:0] s2_vx;
  logic [O_WIDTH-1:0] s2_ox;
  logic [1:0]         s2_sel;
  logic               s2_neg;
  logic               s2_wrap;
  logic [18:0]        s2_val;

  // Output registers
  logic               out_valid_q;
  logic [15:0]        wave_q;
  logic [V_WIDTH-1:0] vx_q;
  logic [O_WIDTH-1:0] ox_q;
  logic               wrap_q;

  logic [V_WIDTH+O_WIDTH-1:0] r0_slot;
  logic                       wrap_c;
  logic [9:0]                 u;
  logic [9:0]                 t;
  logic [18:0]                m;
  logic [15:0]                shaped;
  logic [15:0]                s_mag;
  logic [15:0]                finish;

  assign r0_slot = {r0_vx, r0_ox};
  assign wrap_c  = r0_valid & prev_msb[r0_slot] & ~r0_p[10];

  always_comb begin
    u      = s1_p[9:0];
    t      = s1_p[10] ? ~u : u;
    m      = {9'd0, u} * (19'd1024 - {9'd0, u});
    shaped = 16'd0;
    case (s1_sel)
      2'd0:    shaped = {~s1_p[10], s1_p[9:0], 5'd0};
      2'd1:    shaped = (s1_p < s1_pw) ? 16'h7fff : 16'h8000;
      2'd2:    shaped = {~t[9], t[8:0], 6'd0};
      default: shaped = 16'd0;
    endcase
  end

  // m peaks at exactly 2^18, so m>>3 can only overflow to 0x8000.
  always_comb begin
    s_mag = s2_val[18:3];
    if (s_mag[15]) s_mag = 16'h7fff;
    finish = s2_val[15:0];
    if (s2_sel == 2'd3) finish = s2_neg ? (16'd0 - s_mag) : s_mag;
  end

  always_ff @(posedge sCLK_XVXOSC or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      r0_valid    <= 1'b0;
      r0_p        <= '0;
      r0_vx       <= '0;
      r0_ox       <= '0;
      r0_sel      <= '0;
      r0_pw       <= '0;
      prev_msb    <= '0;
      s1_valid    <= 1'b0;
      s1_p        <= '0;
      s1_vx       <= '0;
      s1_ox       <= '0;
      s1_sel      <= '0;
      s1_pw       <= '0;
      s1_wrap     <= 1'b0;
      s2_valid    <= 1'b0;
      s2_vx       <= '0;
      s2_ox       <= '0;
      s2_sel      <= '0;
      s2_neg      <= 1'b0;
      s2_wrap     <= 1'b0;
      s2_val      <= '0;
      out_valid_q <= 1'b0;
      wave_q      <= '0;
      vx_q        <= '0;
      ox_q        <= '0;
      wrap_q      <= 1'b0;
    end else begin
      r0_valid <= bus.in_valid;
      r0_p     <= bus.phase_acc;
      r0_vx    <= bus.vx;
      r0_ox    <= bus.ox;
      r0_sel   <= bus.wave_sel;
      r0_pw    <= bus.pulse_width;

      // Back-to-back samples of one slot see each other's MSB on the next edge.
      if (r0_valid) prev_msb[r0_slot] <= r0_p[10];
      s1_valid <= r0_valid;
      s1_p     <= r0_p;
      s1_vx    <= r0_vx;
      s1_ox    <= r0_ox;
      s1_sel   <= r0_sel;
      s1_pw    <= r0_pw;
      s1_wrap  <= wrap_c;

      s2_valid <= s1_valid;
      s2_vx    <= s1_vx;
      s2_ox    <= s1_ox;
      s2_sel   <= s1_sel;
      s2_neg   <= s1_p[10];
      s2_wrap  <= s1_wrap;
      s2_val   <= (s1_sel == 2'd3) ? m : {3'd0, shaped};

      out_valid_q <= s2_valid;
      wrap_q      <= s2_valid & s2_wrap;
      if (s2_valid) begin
        wave_q <= finish;
        vx_q   <= s2_vx;
        ox_q   <= s2_ox;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.wave_out  = wave_q;
  assign bus.vx_out    = vx_q;
  assign bus.ox_out    = ox_q;
  assign bus.wrap_out  = wrap_q;

endmodule
